// File: rtl/gpr_pkg.sv
// Shared defaults and helpers for the general-purpose register file slice.
package gpr_pkg;

  localparam int unsigned GPR_DATA_W   = 32;
  localparam int unsigned GPR_NUM_REGS = 16;

  localparam logic [GPR_DATA_W-1:0] ZERO_WORD = '0;

  // Register index width for a given register count; never narrower than one bit.
  function automatic int unsigned calcAddrW(input int unsigned numRegs);
    return (numRegs < 2) ? 1 : $clog2(numRegs);
  endfunction

endpackage : gpr_pkg

// File: rtl/gpr_file_scoreboard_if.sv
// Read/write/issue bus between the control unit and the register file.
interface gpr_file_scoreboard_if
  import gpr_pkg::*;
#(
  parameter int unsigned DATA_W   = GPR_DATA_W,
  parameter int unsigned NUM_REGS = GPR_NUM_REGS
) ();

  localparam int unsigned ADDR_W = calcAddrW(NUM_REGS);

  logic [ADDR_W-1:0]   rd_addr_a;
  logic                ba_a;
  logic [DATA_W-1:0]   rd_data_a;
  logic                busy_a;

  logic [ADDR_W-1:0]   rd_addr_b;
  logic                ba_b;
  logic [DATA_W-1:0]   rd_data_b;
  logic                busy_b;

  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;

  logic                issue_valid;
  logic [ADDR_W-1:0]   issue_dst;
  logic                issue_ready;
  logic [NUM_REGS-1:0] pending;

  // Control unit side.
  modport master (
    output rd_addr_a, ba_a, rd_addr_b, ba_b,
    output wr_en, wr_addr, wr_data,
    output issue_valid, issue_dst,
    input  rd_data_a, busy_a, rd_data_b, busy_b,
    input  issue_ready, pending
  );

  // Register file side.
  modport slave (
    input  rd_addr_a, ba_a, rd_addr_b, ba_b,
    input  wr_en, wr_addr, wr_data,
    input  issue_valid, issue_dst,
    output rd_data_a, busy_a, rd_data_b, busy_b,
    output issue_ready, pending
  );

endinterface : gpr_file_scoreboard_if

// File: rtl/gpr_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on accepted issue,
// cleared by the retiring write; a same-register set and clear leaves it set.
module gpr_scoreboard #(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned ADDR_W   = 4
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                issueValid,
  input  logic [ADDR_W-1:0]   issueDst,
  input  logic                wrEn,
  input  logic [ADDR_W-1:0]   wrAddr,
  output logic                issueReady,
  output logic [NUM_REGS-1:0] pending
);

  logic [NUM_REGS-1:0] setMask;
  logic [NUM_REGS-1:0] clrMask;
  logic [NUM_REGS-1:0] pendingNext;

  // A destination can only be issued while no earlier write to it is outstanding.
  assign issueReady = !pending[issueDst];

  // Build set/clear masks; set is applied after clear so it wins on a tie.
  always_comb begin
    setMask = '0;
    clrMask = '0;
    if (wrEn) begin
      clrMask[wrAddr] = 1'b1;
    end
    if (issueValid && issueReady) begin
      setMask[issueDst] = 1'b1;
    end
    pendingNext = (pending & ~clrMask) | setMask;
  end

  // Scoreboard state register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pending <= '0;
    end else begin
      pending <= pendingNext;
    end
  end

endmodule : gpr_scoreboard

// File: rtl/gpr_file_scoreboard.sv
// General-purpose register file with two registered read ports, BA zeroing of
// register 0 on reads, one write port and a pending-write scoreboard.
// Build option: define GPR_BYPASS_EN to forward same-cycle write data to a
// colliding read; otherwise the read returns the old value flagged busy.
module gpr_file_scoreboard
  import gpr_pkg::*;
#(
  parameter int unsigned DATA_W   = GPR_DATA_W,
  parameter int unsigned NUM_REGS = GPR_NUM_REGS
) (
  input  logic                  Clock,
  input  logic                  Reset,
  gpr_file_scoreboard_if.slave  bus
);

  localparam int unsigned ADDR_W = calcAddrW(NUM_REGS);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] pendingVec;
  logic                issueReady;
  logic [DATA_W-1:0]   nextDataA;
  logic                nextBusyA;
  logic [DATA_W-1:0]   nextDataB;
  logic                nextBusyB;

  gpr_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) scoreboard (
    .Clock      (Clock),
    .Reset      (Reset),
    .issueValid (bus.issue_valid),
    .issueDst   (bus.issue_dst),
    .wrEn       (bus.wr_en),
    .wrAddr     (bus.wr_addr),
    .issueReady (issueReady),
    .pending    (pendingVec)
  );

  assign bus.issue_ready = issueReady;
  assign bus.pending     = pendingVec;

  // Register storage; index 0 is a real register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs[i] <= '0;
      end
    end else if (bus.wr_en) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Port A next value: BA zeroing first, then write collision, else storage.
  always_comb begin
    nextDataA = regs[bus.rd_addr_a];
    nextBusyA = pendingVec[bus.rd_addr_a];
    if (bus.ba_a && (bus.rd_addr_a == '0)) begin
      nextDataA = DATA_W'(ZERO_WORD);
      nextBusyA = 1'b0;
    end else if (bus.wr_en && (bus.wr_addr == bus.rd_addr_a)) begin
`ifdef GPR_BYPASS_EN
      nextDataA = bus.wr_data;
      nextBusyA = 1'b0;
`else
      nextBusyA = 1'b1;
`endif
    end
  end

  // Port B next value, same rules as port A.
  always_comb begin
    nextDataB = regs[bus.rd_addr_b];
    nextBusyB = pendingVec[bus.rd_addr_b];
    if (bus.ba_b && (bus.rd_addr_b == '0)) begin
      nextDataB = DATA_W'(ZERO_WORD);
      nextBusyB = 1'b0;
    end else if (bus.wr_en && (bus.wr_addr == bus.rd_addr_b)) begin
`ifdef GPR_BYPASS_EN
      nextDataB = bus.wr_data;
      nextBusyB = 1'b0;
`else
      nextBusyB = 1'b1;
`endif
    end
  end

  // Read data and stale flags registered together.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      bus.rd_data_a <= '0;
      bus.busy_a    <= 1'b0;
      bus.rd_data_b <= '0;
      bus.busy_b    <= 1'b0;
    end else begin
      bus.rd_data_a <= nextDataA;
      bus.busy_a    <= nextBusyA;
      bus.rd_data_b <= nextDataB;
      bus.busy_b    <= nextBusyB;
    end
  end

endmodule : gpr_file_scoreboard

// File: tb/tb_gpr_file_scoreboard.sv
// Directed bench for gpr_file_scoreboard; expectations adapt to GPR_BYPASS_EN.
module tb_gpr_file_scoreboard;

  parameter int unsigned NUM_REGS = 16;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = $clog2(NUM_REGS);

  logic Clock;
  logic Reset;

  int vectors;
  int miscompares;

  logic [NUM_REGS-1:0] expPend;

  gpr_file_scoreboard_if #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) bus ();

  gpr_file_scoreboard #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic idle();
    bus.rd_addr_a   = '0;
    bus.ba_a        = 1'b0;
    bus.rd_addr_b   = '0;
    bus.ba_b        = 1'b0;
    bus.wr_en       = 1'b0;
    bus.wr_addr     = '0;
    bus.wr_data     = '0;
    bus.issue_valid = 1'b0;
    bus.issue_dst   = '0;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    idle();
    Reset = 1'b0;
    #3;
    check("reset_rd_data_a", 64'(bus.rd_data_a), 64'h0);
    check("reset_busy_a",    64'(bus.busy_a),    64'h0);
    check("reset_pending",   64'(bus.pending),   64'h0);
    #9 Reset = 1'b1;
    tick();

    // 1: write R3, read it back, then async reset mid-cycle
    bus.wr_en = 1'b1; bus.wr_addr = ADDR_W'(3); bus.wr_data = 32'hDEADBEEF;
    tick();
    idle();
    bus.rd_addr_a = ADDR_W'(3);
    bus.issue_valid = 1'b1; bus.issue_dst = ADDR_W'(6);
    tick();
    idle();
    bus.rd_addr_a = ADDR_W'(3);
    expPend = '0; expPend[6] = 1'b1;
    check("t1_rd_data_a", 64'(bus.rd_data_a), 64'hDEADBEEF);
    check("t1_pending_pre", 64'(bus.pending), 64'(expPend));
    #2 Reset = 1'b0;
    #1;
    check("t1_async_rd_data_a", 64'(bus.rd_data_a), 64'h0);
    check("t1_async_pending",   64'(bus.pending),   64'h0);
    #2 Reset = 1'b1;
    tick();
    check("t1_r3_cleared", 64'(bus.rd_data_a), 64'h0);

    // 2: plain write then read
    idle();
    bus.wr_en = 1'b1; bus.wr_addr = ADDR_W'(5); bus.wr_data = 32'h12345678;
    tick();
    idle();
    bus.rd_addr_a = ADDR_W'(5);
    tick();
    check("t2_rd_data_a", 64'(bus.rd_data_a), 64'h12345678);
    check("t2_busy_a",    64'(bus.busy_a),    64'h0);

    // 3: R0 is writable; BA zeroes only the BA read
    idle();
    bus.wr_en = 1'b1; bus.wr_addr = ADDR_W'(0); bus.wr_data = 32'hFFFF0000;
    tick();
    idle();
    bus.rd_addr_a = ADDR_W'(0); bus.ba_a = 1'b1;
    bus.rd_addr_b = ADDR_W'(0); bus.ba_b = 1'b0;
    tick();
    check("t3_rd_data_a_ba", 64'(bus.rd_data_a), 64'h0);
    check("t3_rd_data_b",    64'(bus.rd_data_b), 64'hFFFF0000);

    // 4: read/write collision on R7
    idle();
    bus.wr_en = 1'b1; bus.wr_addr = ADDR_W'(7); bus.wr_data = 32'h1;
    tick();
    bus.wr_data = 32'hA5A5A5A5;
    bus.rd_addr_a = ADDR_W'(7);
    tick();
`ifdef GPR_BYPASS_EN
    check("t4_collide_data", 64'(bus.rd_data_a), 64'hA5A5A5A5);
    check("t4_collide_busy", 64'(bus.busy_a),    64'h0);
`else
    check("t4_collide_data", 64'(bus.rd_data_a), 64'h1);
    check("t4_collide_busy", 64'(bus.busy_a),    64'h1);
`endif
    idle();
    bus.rd_addr_a = ADDR_W'(7);
    tick();
    check("t4_reread_data", 64'(bus.rd_data_a), 64'hA5A5A5A5);
    check("t4_reread_busy", 64'(bus.busy_a),    64'h0);

    // 5: issue R9, blocked re-issue, busy read, retire
    idle();
    bus.issue_valid = 1'b1; bus.issue_dst = ADDR_W'(9);
    #1;
    check("t5_ready_free", 64'(bus.issue_ready), 64'h1);
    tick();
    expPend = '0; expPend[9] = 1'b1;
    check("t5_pending_set", 64'(bus.pending), 64'(expPend));
    check("t5_ready_blocked", 64'(bus.issue_ready), 64'h0);
    tick();
    check("t5_pending_held", 64'(bus.pending), 64'(expPend));
    idle();
    bus.rd_addr_b = ADDR_W'(9);
    tick();
    check("t5_busy_b", 64'(bus.busy_b), 64'h1);
    bus.wr_en = 1'b1; bus.wr_addr = ADDR_W'(9); bus.wr_data = 32'h99;
    tick();
    check("t5_pending_retired", 64'(bus.pending), 64'h0);
`ifdef GPR_BYPASS_EN
    check("t5_collide_data", 64'(bus.rd_data_b), 64'h99);
    check("t5_collide_busy", 64'(bus.busy_b),    64'h0);
`else
    check("t5_collide_data", 64'(bus.rd_data_b), 64'h0);
    check("t5_collide_busy", 64'(bus.busy_b),    64'h1);
`endif
    idle();
    bus.rd_addr_b = ADDR_W'(9);
    tick();
    check("t5_reread_data", 64'(bus.rd_data_b), 64'h99);
    check("t5_reread_busy", 64'(bus.busy_b),    64'h0);

    // 6: simultaneous issue/retire, different and same registers
    idle();
    bus.issue_valid = 1'b1; bus.issue_dst = ADDR_W'(2);
    tick();
    idle();
    bus.issue_valid = 1'b1; bus.issue_dst = ADDR_W'(4);
    bus.wr_en = 1'b1; bus.wr_addr = ADDR_W'(2); bus.wr_data = 32'h22;
    tick();
    expPend = '0; expPend[4] = 1'b1;
    check("t6_issue4_retire2", 64'(bus.pending), 64'(expPend));
    idle();
    bus.issue_valid = 1'b1; bus.issue_dst = ADDR_W'(12);
    bus.wr_en = 1'b1; bus.wr_addr = ADDR_W'(12); bus.wr_data = 32'hC;
    tick();
    expPend[12] = 1'b1;
    check("t6_set_wins", 64'(bus.pending), 64'(expPend));
    idle();
    bus.rd_addr_a = ADDR_W'(12);
    tick();
    check("t6_r12_data", 64'(bus.rd_data_a), 64'hC);
    check("t6_r12_busy", 64'(bus.busy_a),    64'h1);

    // BA zeroing masks busy on a pending R0
    idle();
    bus.issue_valid = 1'b1; bus.issue_dst = ADDR_W'(0);
    tick();
    idle();
    bus.rd_addr_a = ADDR_W'(0); bus.ba_a = 1'b1;
    bus.rd_addr_b = ADDR_W'(0); bus.ba_b = 1'b0;
    tick();
    check("ba_busy_a_masked", 64'(bus.busy_a),    64'h0);
    check("ba_data_a_zero",   64'(bus.rd_data_a), 64'h0);
    check("nba_busy_b",       64'(bus.busy_b),    64'h1);
    check("nba_data_b",       64'(bus.rd_data_b), 64'hFFFF0000);

    idle();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_gpr_file_scoreboard
